sti_dac: RTL and testbench

- Combines a serial transmitter with a data-arrangement controller.
- STI: each load captures a 16-bit word plus format controls, then shifts out an 8/16/24/32-bit serial stream with a valid strobe.
- DAC: packs the serial stream into 8-bit pixels of a 16x16 image. Each pixel is written into one of eight 32-byte banks (odd1..odd4, even1..even4) in a checkerboard/row-band split.
- After the last word, the DAC zero-fills the remaining pixels and signals completion.

---
 rtl/sti_dac_pkg.sv | 35 +++
 rtl/sti_serializer.sv | 78 +++++++
 rtl/sti_dac.sv | 128 ++++++++++++
 tb/tb_sti_dac.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_dac_pkg.sv
// Shared types and constants for the sti_dac serial transmitter and
// pixel bank arranger.
package sti_dac_pkg;

  localparam logic [1:0] LEN8  = 2'b00;
  localparam logic [1:0] LEN16 = 2'b01;
  localparam logic [1:0] LEN24 = 2'b10;
  localparam logic [1:0] LEN32 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FILL,
    DONE
  } state_t;

  localparam int PIX_TOTAL  = 256;
  localparam int BANK_DEPTH = 32;
  localparam int ADDR_W     = $clog2(BANK_DEPTH);

  // row = p[7:4], col = p[3:0]
  function automatic logic [ADDR_W-1:0] bank_addr(
    input logic [7:0] p
  );
    return {p[5:4], p[3:1]};
  endfunction

  // {odd, bank}: odd when row[0]^col[0], bank = row[3:2]
  function automatic logic [2:0] bank_sel(
    input logic [7:0] p
  );
    return {p[4] ^ p[0], p[7:6]};
  endfunction

endpackage

// File: rtl/sti_serializer.sv
// Captures one formatted word per load and shifts it out one bit per
// cycle, MSB- or LSB-first, with a valid strobe and last-bit flag.
module sti_serializer
  import sti_dac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        so_data,
  output logic        so_valid,
  output logic        last,
  output logic        end_flag
);

  logic [31:0] word;
  logic [31:0] aligned;
  logic [5:0]  nbits;
  logic [31:0] sreg;
  logic [5:0]  cnt;
  logic        msb_q;
  logic        end_q;

  always_comb begin
    word  = 32'h0;
    nbits = 6'd8;
    unique case (pi_length)
      LEN8: begin
        word  = {24'h0, pi_low ? pi_data[15:8] : pi_data[7:0]};
        nbits = 6'd8;
      end
      LEN16: begin
        word  = {16'h0, pi_data};
        nbits = 6'd16;
      end
      LEN24: begin
        word  = pi_fill ? {8'h0, pi_data, 8'h00}
                        : {16'h0, pi_data};
        nbits = 6'd24;
      end
      LEN32: begin
        word  = pi_fill ? {pi_data, 16'h0}
                        : {16'h0, pi_data};
        nbits = 6'd32;
      end
    endcase
    // MSB-first streams are left-aligned so bit 31 always leads
    aligned = pi_msb ? word << (6'd32 - nbits) : word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= 32'h0;
      cnt   <= 6'd0;
      msb_q <= 1'b0;
      end_q <= 1'b0;
    end else if (accept) begin
      sreg  <= aligned;
      cnt   <= nbits;
      msb_q <= pi_msb;
      end_q <= pi_end;
    end else if (cnt != 6'd0) begin
      sreg <= msb_q ? sreg << 1 : sreg >> 1;
      cnt  <= cnt - 6'd1;
    end
  end

  assign so_valid = cnt != 6'd0;
  assign so_data  = so_valid & (msb_q ? sreg[31] : sreg[0]);
  assign last     = cnt == 6'd1;
  assign end_flag = end_q;

endmodule

// File: rtl/sti_dac.sv
// Serial transmitter plus byte packer that scatters a 16x16 image over
// eight 32-byte banks, zero-filling the tail after the final word.
module sti_dac
  import sti_dac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        so_data,
  output logic        so_valid,
  output logic        oem_finish,
  output logic [4:0]  oem_addr,
  output logic [7:0]  oem_dataout,
  output logic        odd1_wr,
  output logic        odd2_wr,
  output logic        odd3_wr,
  output logic        odd4_wr,
  output logic        even1_wr,
  output logic        even2_wr,
  output logic        even3_wr,
  output logic        even4_wr
);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        last;
  logic        end_flag;
  logic [8:0]  pix_cnt;
  logic [6:0]  pix_sr;
  logic [2:0]  bit_cnt;
  logic        wr_pend;
  logic [2:0]  wr_sel;
  logic [7:0]  wr_vec;
  logic        full;
  logic        byte_done;
  logic        fill_go;
  logic        issue;
  logic        quiet;

  assign accept = load && (state == IDLE);

  sti_serializer u_ser (
    .clk       (clk),
    .rst_n     (reset),
    .accept    (accept),
    .pi_data   (pi_data),
    .pi_length (pi_length),
    .pi_fill   (pi_fill),
    .pi_msb    (pi_msb),
    .pi_low    (pi_low),
    .pi_end    (pi_end),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .last      (last),
    .end_flag  (end_flag)
  );

  assign full      = pix_cnt == 9'(PIX_TOTAL);
  assign byte_done = so_valid && (bit_cnt == 3'd7) && !full;
  // a pending strobe blocks the next fill write, giving a 2-cycle cadence
  assign fill_go   = (state == FILL) && !wr_pend && !full;
  assign issue     = byte_done || fill_go;
  assign quiet     = full && !wr_pend && (wr_vec == 8'h00);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (quiet)     state_nx = DONE;
        else if (load) state_nx = SHIFT;
      end
      SHIFT: begin
        if (quiet)     state_nx = DONE;
        else if (last) state_nx = end_flag ? FILL : IDLE;
      end
      FILL: begin
        if (quiet)     state_nx = DONE;
      end
      DONE: state_nx = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pix_cnt     <= 9'd0;
      pix_sr      <= 7'd0;
      bit_cnt     <= 3'd0;
      wr_pend     <= 1'b0;
      wr_sel      <= 3'd0;
      wr_vec      <= 8'h00;
      oem_addr    <= 5'd0;
      oem_dataout <= 8'h00;
    end else begin
      state <= state_nx;
      if (so_valid) begin
        pix_sr  <= {pix_sr[5:0], so_data};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (issue) begin
        oem_addr    <= bank_addr(pix_cnt[7:0]);
        oem_dataout <= byte_done ? {pix_sr, so_data} : 8'h00;
        wr_sel      <= bank_sel(pix_cnt[7:0]);
        pix_cnt     <= pix_cnt + 9'd1;
      end
      wr_pend <= issue;
      wr_vec  <= wr_pend ? (8'h01 << wr_sel) : 8'h00;
    end
  end

  assign even1_wr   = wr_vec[0];
  assign even2_wr   = wr_vec[1];
  assign even3_wr   = wr_vec[2];
  assign even4_wr   = wr_vec[3];
  assign odd1_wr    = wr_vec[4];
  assign odd2_wr    = wr_vec[5];
  assign odd3_wr    = wr_vec[6];
  assign odd4_wr    = wr_vec[7];
  assign oem_finish = state == DONE;

endmodule

// File: tb/tb_sti_dac.sv
// Scoreboard bench for sti_dac: serial bits and bank writes are predicted
// when each load is driven and checked as the DUT produces them.
module tb_sti_dac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] pi_data = 16'h0;
  logic [1:0]  pi_length = 2'b00;
  logic        pi_fill = 1'b0;
  logic        pi_msb = 1'b0;
  logic        pi_low = 1'b0;
  logic        pi_end = 1'b0;
  logic        so_data, so_valid, oem_finish;
  logic [4:0]  oem_addr;
  logic [7:0]  oem_dataout;
  logic        odd1_wr, odd2_wr, odd3_wr, odd4_wr;
  logic        even1_wr, even2_wr, even3_wr, even4_wr;

  sti_dac dut (
    .clk(clk), .reset(reset), .load(load),
    .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end),
    .so_data(so_data), .so_valid(so_valid),
    .oem_finish(oem_finish), .oem_addr(oem_addr),
    .oem_dataout(oem_dataout),
    .odd1_wr(odd1_wr), .odd2_wr(odd2_wr),
    .odd3_wr(odd3_wr), .odd4_wr(odd4_wr),
    .even1_wr(even1_wr), .even2_wr(even2_wr),
    .even3_wr(even3_wr), .even4_wr(even4_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    int         addr;
    logic [7:0] data;
  } wr_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_wr_cyc = -100;
  logic       bitq[$];
  wr_t        wq[$];
  logic [7:0] mem_tb[8][32];
  logic [7:0] mem_exp[8][32];
  logic [7:0] acc = 8'h0;
  int         accn = 0;
  int         pm = 0;
  logic [7:0] prev_wv = 8'h0;

  function automatic logic [7:0] wvec();
    return {odd4_wr, odd3_wr, odd2_wr, odd1_wr,
            even4_wr, even3_wr, even2_wr, even1_wr};
  endfunction

  always @(negedge clk) begin
    logic [7:0] wv;
    logic       eb;
    int         idx;
    wr_t        w;
    if (reset) begin
      cyc++;
      if (so_valid) begin
        vectors++;
        if (bitq.size() == 0) begin
          miscompares++;
          $display("FAIL so_data: unexpected bit %b, none queued", so_data);
        end else begin
          eb = bitq.pop_front();
          if (so_data !== eb) begin
            miscompares++;
            $display("FAIL so_data: got %b need %b", so_data, eb);
          end
        end
      end
      wv = wvec();
      if (wv != 8'h00) begin
        vectors++;
        if ($countones(wv) != 1 || prev_wv != 8'h00) begin
          miscompares++;
          $display("FAIL wr_strobe: got %b prev %b need one-hot after low", wv, prev_wv);
        end
        idx = 0;
        for (int i = 0; i < 8; i++) if (wv[i]) idx = i;
        mem_tb[idx][oem_addr] = oem_dataout;
        last_wr_cyc = cyc;
        if (wq.size() == 0) begin
          miscompares++;
          $display("FAIL write: unexpected bank %0d addr %0d data %h", idx, oem_addr, oem_dataout);
        end else begin
          w = wq.pop_front();
          if (idx != w.idx || oem_addr !== w.addr[4:0] || oem_dataout !== w.data) begin
            miscompares++;
            $display("FAIL write: got bank %0d addr %0d data %h need bank %0d addr %0d data %h",
                     idx, oem_addr, oem_dataout, w.idx, w.addr, w.data);
          end
        end
      end
      prev_wv = wv;
    end else begin
      prev_wv = 8'h00;
    end
  end

  task automatic clear_model();
    bitq.delete();
    wq.delete();
    acc = 8'h0;
    accn = 0;
    pm = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 32; j++) begin
        mem_tb[i][j] = 8'hxx;
        mem_exp[i][j] = 8'hxx;
      end
  endtask

  task automatic apply_reset();
    load = 1'b0;
    pi_end = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    reset = 1'b1;
  endtask

  task automatic push_pixel(input int p, input logic [7:0] d);
    int  row, col, odd;
    wr_t w;
    row = p / 16;
    col = p % 16;
    odd = (row + col) % 2;
    w.idx = odd * 4 + row / 4;
    w.addr = (row % 4) * 8 + col / 2;
    w.data = d;
    wq.push_back(w);
    mem_exp[w.idx][w.addr] = d;
  endtask

  task automatic push_bit(input logic b);
    bitq.push_back(b);
    acc = {acc[6:0], b};
    accn++;
    if (accn == 8) begin
      accn = 0;
      if (pm < 256) push_pixel(pm, acc);
      pm++;
    end
  endtask

  task automatic gen_bits(input logic [15:0] d, input logic [1:0] len,
                          input logic f, input logic m, input logic lo,
                          output int n);
    logic [31:0] w;
    case (len)
      2'b00: begin n = 8;  w = {24'h0, lo ? d[15:8] : d[7:0]}; end
      2'b01: begin n = 16; w = {16'h0, d}; end
      2'b10: begin n = 24; w = f ? {8'h0, d, 8'h0} : {16'h0, d}; end
      default: begin n = 32; w = f ? {d, 16'h0} : {16'h0, d}; end
    endcase
    for (int i = 0; i < n; i++) push_bit(m ? w[n-1-i] : w[i]);
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] len,
                       input logic f, input logic m, input logic lo,
                       input logic e, output int n);
    @(negedge clk);
    pi_data = d;
    pi_length = len;
    pi_fill = f;
    pi_msb = m;
    pi_low = lo;
    pi_end = e;
    load = 1'b1;
    gen_bits(d, len, f, m, lo, n);
    if (e) begin
      for (int p = pm; p < 256; p++) push_pixel(p, 8'h00);
      pm = 256;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [1:0] len,
                         input logic f, input logic m, input logic lo,
                         input logic e);
    int n;
    drive(d, len, f, m, lo, e, n);
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (so_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL so_valid: bit %0d of %0d got %b need 1", i, n, so_valid);
      end
      @(negedge clk);
    end
    vectors++;
    if (so_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL so_valid_end: got %b need 0 after %0d bits", so_valid, n);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({so_valid, so_data} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_serial: got %b need 00", {so_valid, so_data});
    end
    vectors++;
    if (oem_finish !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_finish: got %b need 0", oem_finish);
    end
    vectors++;
    if ({oem_addr, oem_dataout} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr %h data %h need 0", oem_addr, oem_dataout);
    end
    vectors++;
    if (wvec() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_wr: got %b need 0", wvec());
    end
    clear_model();
    reset = 1'b1;
  endtask

  task automatic test_len16();
    do_load(16'h1234, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (wq.size() != 0 || bitq.size() != 0) begin
      miscompares++;
      $display("FAIL len16_drain: got %0d writes %0d bits left need 0", wq.size(), bitq.size());
    end
    vectors++;
    if (mem_tb[0][0] !== 8'h12 || mem_tb[4][0] !== 8'h34) begin
      miscompares++;
      $display("FAIL len16_pix: got even1[0]=%h odd1[0]=%h need 12 34", mem_tb[0][0], mem_tb[4][0]);
    end
  endtask

  task automatic test_len8();
    do_load(16'hA5C3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (wq.size() != 0 || mem_tb[0][1] !== 8'hA5) begin
      miscompares++;
      $display("FAIL len8: got even1[1]=%h with %0d writes left need a5 0", mem_tb[0][1], wq.size());
    end
  endtask

  task automatic test_len24();
    do_load(16'hFFFF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    do_load(16'hFFFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (wq.size() != 0 || bitq.size() != 0) begin
      miscompares++;
      $display("FAIL len24_drain: got %0d writes %0d bits left need 0", wq.size(), bitq.size());
    end
  endtask

  task automatic test_len32();
    do_load(16'h8001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (wq.size() != 0 || bitq.size() != 0) begin
      miscompares++;
      $display("FAIL len32_drain: got %0d writes %0d bits left need 0", wq.size(), bitq.size());
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    drive(16'hBEEF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, n);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({so_valid, oem_finish} !== 2'b00 || wvec() !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got valid %b finish %b wr %b need 0", so_valid, oem_finish, wvec());
    end
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    do_load(16'h5AA5, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (mem_tb[0][0] !== 8'h5A || mem_tb[4][0] !== 8'hA5 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL restart: got even1[0]=%h odd1[0]=%h need 5a a5", mem_tb[0][0], mem_tb[4][0]);
    end
  endtask

  task automatic wait_finish(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (oem_finish === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_finish: got no oem_finish within 3000 cycles", name);
    end else begin
      vectors++;
      if (cyc != last_wr_cyc + 2) begin
        miscompares++;
        $display("FAIL %s_finish_time: got cycle %0d need %0d", name, cyc, last_wr_cyc + 2);
      end
    end
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL %s_writes: got %0d writes missing need 0", name, wq.size());
    end
  endtask

  task automatic compare_banks(input string name);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 32; j++) begin
        vectors++;
        if (mem_tb[i][j] !== mem_exp[i][j]) begin
          miscompares++;
          $display("FAIL %s_bank: bank %0d addr %0d got %h need %h", name, i, j, mem_tb[i][j], mem_exp[i][j]);
        end
      end
  endtask

  task automatic test_image();
    apply_reset();
    for (int k = 0; k < 12; k++)
      do_load({8'(32 + 2 * k), 8'(33 + 2 * k)}, 2'b01, 1'b0, 1'b1, 1'b0, k == 11);
    wait_finish("image");
    vectors++;
    if (mem_tb[4][8] !== 8'h30 || mem_tb[0][8] !== 8'h31) begin
      miscompares++;
      $display("FAIL image_map: got odd1[8]=%h even1[8]=%h need 30 31", mem_tb[4][8], mem_tb[0][8]);
    end
    compare_banks("image");
  endtask

  task automatic test_full_image();
    apply_reset();
    for (int k = 0; k < 128; k++)
      do_load({8'(k), 8'(255 - k)}, 2'b01, 1'b0, 1'(k % 2), 1'b0, 1'b0);
    wait_finish("full");
    compare_banks("full");
    @(negedge clk);
    pi_data = 16'hFFFF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (so_valid !== 1'b0 || oem_finish !== 1'b1) begin
        miscompares++;
        $display("FAIL done_hold: got valid %b finish %b need 0 1", so_valid, oem_finish);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_len16();
    test_len8();
    test_len24();
    test_len32();
    test_reset_mid_shift();
    test_image();
    test_full_image();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
